microstep_phase_gen: RTL and testbench
======================================

# microstep_phase_gen

Step/direction front end for the microstepper. It converts externally driven `step` and `dir` pins into the 8-bit electrical phase position `pos`, in the range 0–191. The phase table counter consumes `pos` to produce the cosine index and quadrant switches. The block also keeps a signed absolute microstep count and supports a synchronous position load for homing.

## Interface
Parameters:
- `COUNT_WIDTH`, default 32. Width of the signed absolute microstep counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset.
- `step`  in  1  asynchronous step pin; each rising edge is one step request.
- `dir`  in  1  asynchronous direction pin: 1 = forward (increasing phase), 0 = reverse.
- `enable`  in  1  synchronous to `clk`; when low, step edges are dropped.
- `inc`  in  6  synchronous to `clk`; phase increment per step, valid range 1–48 (48 = full step).
- `load`  in  1  synchronous to `clk`; one-cycle strobe that loads the phase and clears the count.
- `load_pos`  in  8  synchronous to `clk`; phase value used on `load`.
- `pos`  out  8  registered electrical phase, always within 0–191.
- `count`  out  COUNT_WIDTH  registered signed absolute position, in microsteps of 1/48 full step.
- `moved`  out  1  registered one-cycle pulse marking an accepted step.
- `inc_err`  out  1  registered sticky flag: a step arrived while `inc` was invalid.

## Operation
- Synchronizer:
  - `step` passes through a 3-flop chain s1→s2→s3.
  - `dir` passes through a 2-flop chain d1→d2.
  - An edge is detected when s2=1 and s3=0. The direction used is d2 in that same cycle.
- Step acceptance: a detected edge is accepted only if `enable`=1, `load`=0, and 1 ≤ `inc` ≤ 48.
- Forward step:
  - Compute t = `pos` + `inc` in 9 bits.
  - `pos` ← t−192 if t ≥ 192, else t.
  - `count` ← `count` + `inc`.
- Reverse step:
  - Compute t = `pos` − `inc` in 9-bit signed arithmetic.
  - `pos` ← t+192 if t < 0, else t.
  - `count` ← `count` − `inc`.
- `count` wraps in two's complement at COUNT_WIDTH with no saturation.
- Invalid increment: an edge that would otherwise be accepted while `inc` = 0 or `inc` > 48 sets `inc_err` to 1. `pos`, `count` and `moved` are unchanged.
- Disabled: edges detected while `enable`=0 are discarded silently. They are not queued and do not set the error flag.
- Load:
  - `pos` ← `load_pos` if `load_pos` < 192, else `load_pos`−192.
  - `count` ← 0 and `inc_err` ← 0.
  - `load` has priority over an edge in the same cycle; that edge is lost.
  - `moved` stays 0 on a load.
- `moved` is 1 in exactly the cycle after an accepted step, i.e. together with the new `pos` and `count`.
- Reset (asynchronous, any time, including mid-edge):
  - `pos`=0, `count`=0, `moved`=0, `inc_err`=0.
  - All synchronizer flops are cleared to 0. If `step` is already high at reset release, one edge is detected after release.

## Timing
- Step latency: `step` rises before clk edge 1 with setup met, so s1=1 after edge 1 and s2=1 after edge 2. `pos`, `count` and `moved` update on edge 3.
- Direction: `dir` must be stable at least 2 clk cycles before `step` rises and until `moved` is seen.
- Step pin: minimum high time 3 clk, minimum low time 3 clk. Maximum accepted rate is one step per 6 clk.
- `inc`, `enable` and `load` are sampled in the cycle the edge is detected (the cycle before the update).
- Load latency: a `load` high in cycle n gives the new `pos` and `count`=0 visible in cycle n+1.
- `pos` never takes a value ≥ 192 in any cycle.

## Test plan
- Forward wrap:
  - Stimulus: reset, `inc`=4, `dir`=1, 48 step pulses.
  - Required: `pos` visits 4, 8, …, 188, 0; `count`=192; 48 `moved` pulses; each update exactly 3 clk after the `step` rise.
- Reverse wrap:
  - Stimulus: load `load_pos`=1, then `dir`=0, `inc`=4, one step.
  - Required: `pos`=189, `count`=−4.
- Full step across the boundary:
  - Stimulus: load `load_pos`=144, then `inc`=48 forward ×2, then reverse ×3.
  - Required: `pos` sequence 0, 48, 0, 144, 96; final `count`=−48.
- Invalid increment and error clear:
  - Stimulus: `inc`=0, one step; then `inc`=49, one step.
  - Required: `pos` and `count` unchanged, no `moved`, `inc_err`=1.
  - Follow-up: `load` with `load_pos`=200 → `pos`=8, `count`=0, `inc_err`=0.
- Enable, load collision and reset:
  - `enable`=0 with 5 steps → no change.
  - `load` asserted in the same cycle the edge is detected → load applied, step dropped, `moved`=0.
  - `resetn` pulsed low between edge 2 and edge 3 of a step → all outputs 0 and no update afterwards while `step` stays low.

Source files
------------

// File: rtl/microstep_phase_gen.sv
// rtl/microstep_phase_gen.sv - step/direction to electrical phase position front end
module microstep_phase_gen #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   step,
    input  logic                   dir,
    input  logic                   enable,
    input  logic [5:0]             inc,
    input  logic                   load,
    input  logic [7:0]             load_pos,
    output logic [7:0]             pos,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   moved,
    output logic                   inc_err
);

    localparam logic [8:0] PHASE_SPAN = 9'd192;

    // step goes through three flops so the third can serve as the edge reference
    logic s1_q, s2_q, s3_q;
    logic d1_q, d2_q;

    logic [7:0]             pos_q, pos_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   moved_q, moved_d;
    logic                   inc_err_q, inc_err_d;

    logic                   step_edge;
    logic                   inc_valid;
    logic                   accept;
    logic [8:0]             fwd_t;
    logic signed [8:0]      rev_t;
    logic [7:0]             fwd_pos;
    logic [7:0]             rev_pos;
    logic [7:0]             load_pos_wrapped;
    logic [8:0]             rev_fix;
    logic [COUNT_WIDTH-1:0] inc_ext;

    assign step_edge = s2_q & ~s3_q;
    assign inc_valid = (inc != 6'd0) && (inc <= 6'd48);
    assign accept    = step_edge && enable && !load;
    assign inc_ext   = COUNT_WIDTH'(inc);

    // Both wrap candidates are formed in 9 bits; pos < 192 and inc <= 48 keep them in range
    assign fwd_t   = {1'b0, pos_q} + {3'b000, inc};
    assign fwd_pos = (fwd_t >= PHASE_SPAN) ? 8'(fwd_t - PHASE_SPAN) : fwd_t[7:0];
    assign rev_t   = $signed({1'b0, pos_q}) - $signed({3'b000, inc});
    assign rev_fix = (rev_t < 0) ? 9'($unsigned(rev_t) + PHASE_SPAN) : $unsigned(rev_t);
    assign rev_pos = rev_fix[7:0];

    assign load_pos_wrapped = (load_pos < 8'd192) ? load_pos : 8'(load_pos - 8'd192);

    // Next-state selection: load wins over a same-cycle edge, invalid increments only flag
    always_comb begin
        pos_d     = pos_q;
        count_d   = count_q;
        moved_d   = 1'b0;
        inc_err_d = inc_err_q;
        if (load) begin
            pos_d     = load_pos_wrapped;
            count_d   = '0;
            inc_err_d = 1'b0;
        end else if (accept) begin
            if (!inc_valid) begin
                inc_err_d = 1'b1;
            end else if (d2_q) begin
                pos_d   = fwd_pos;
                count_d = count_q + inc_ext;
                moved_d = 1'b1;
            end else begin
                pos_d   = rev_pos;
                count_d = count_q - inc_ext;
                moved_d = 1'b1;
            end
        end
    end

    // Synchronizer chains for the asynchronous step and dir pins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
            d1_q <= 1'b0;
            d2_q <= 1'b0;
        end else begin
            s1_q <= step;
            s2_q <= s1_q;
            s3_q <= s2_q;
            d1_q <= dir;
            d2_q <= d1_q;
        end
    end

    // Registered phase, count, move pulse and sticky error flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_q     <= 8'd0;
            count_q   <= '0;
            moved_q   <= 1'b0;
            inc_err_q <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            count_q   <= count_d;
            moved_q   <= moved_d;
            inc_err_q <= inc_err_d;
        end
    end

    assign pos     = pos_q;
    assign count   = count_q;
    assign moved   = moved_q;
    assign inc_err = inc_err_q;

endmodule

// File: tb/tb_microstep_phase_gen.sv
// tb/tb_microstep_phase_gen.sv - directed bench for microstep_phase_gen
module tb_microstep_phase_gen;

    logic        clk;
    logic        resetn;
    logic        step;
    logic        dir;
    logic        enable;
    logic [5:0]  inc;
    logic        load;
    logic [7:0]  load_pos;
    logic [7:0]  pos;
    logic [31:0] count;
    logic        moved;
    logic        inc_err;

    int checks;
    int errors;
    int n_moved;

    microstep_phase_gen #(.COUNT_WIDTH(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .step     (step),
        .dir      (dir),
        .enable   (enable),
        .inc      (inc),
        .load     (load),
        .load_pos (load_pos),
        .pos      (pos),
        .count    (count),
        .moved    (moved),
        .inc_err  (inc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One step pulse: 3 cycles high, 3 low; lat = cycle of first moved after the rise, 0 if none
    task automatic step_pulse(output int lat);
        lat = 0;
        @(negedge clk);
        step = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (moved) begin
                n_moved++;
                if (lat == 0) lat = i;
            end
            if (i == 3) step = 1'b0;
        end
    endtask

    task automatic set_dir(input logic d);
        @(negedge clk);
        dir = d;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        load     = 1'b1;
        load_pos = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    int lat;
    int exp_pos;
    int moved_seen;

    initial begin
        checks   = 0;
        errors   = 0;
        n_moved  = 0;
        resetn   = 1'b0;
        step     = 1'b0;
        dir      = 1'b1;
        enable   = 1'b1;
        inc      = 6'd4;
        load     = 1'b0;
        load_pos = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        check("reset_pos", 32'(pos), 32'd0);
        check("reset_count", count, 32'd0);
        check("reset_moved", 32'(moved), 32'd0);
        check("reset_inc_err", 32'(inc_err), 32'd0);

        // Forward wrap with inc=4: 48 steps cover the full 192-phase cycle
        exp_pos = 0;
        for (int k = 0; k < 48; k++) begin
            step_pulse(lat);
            exp_pos = (exp_pos + 4) % 192;
            check("fwd_latency", 32'(lat), 32'd3);
            check("fwd_pos", 32'(pos), 32'(exp_pos));
        end
        check("fwd_count", count, 32'd192);
        check("fwd_moved_pulses", 32'(n_moved), 32'd48);

        // Reverse across zero
        do_load(8'd1);
        check("load1_pos", 32'(pos), 32'd1);
        check("load1_count", count, 32'd0);
        set_dir(1'b0);
        step_pulse(lat);
        check("rev_pos", 32'(pos), 32'd189);
        check("rev_count", count, 32'hFFFF_FFFC);

        // Full steps across the boundary
        do_load(8'd144);
        set_dir(1'b1);
        inc = 6'd48;
        step_pulse(lat);
        check("full_f1", 32'(pos), 32'd0);
        step_pulse(lat);
        check("full_f2", 32'(pos), 32'd48);
        set_dir(1'b0);
        step_pulse(lat);
        check("full_r1", 32'(pos), 32'd0);
        step_pulse(lat);
        check("full_r2", 32'(pos), 32'd144);
        step_pulse(lat);
        check("full_r3", 32'(pos), 32'd96);
        check("full_count", count, 32'hFFFF_FFD0);

        // Invalid increments
        inc = 6'd0;
        step_pulse(lat);
        check("inc0_moved", 32'(lat), 32'd0);
        check("inc0_pos", 32'(pos), 32'd96);
        check("inc0_err", 32'(inc_err), 32'd1);
        inc = 6'd49;
        step_pulse(lat);
        check("inc49_moved", 32'(lat), 32'd0);
        check("inc49_pos", 32'(pos), 32'd96);
        check("inc49_count", count, 32'hFFFF_FFD0);
        check("inc49_err", 32'(inc_err), 32'd1);
        do_load(8'd200);
        check("load200_pos", 32'(pos), 32'd8);
        check("load200_count", count, 32'd0);
        check("load200_err", 32'(inc_err), 32'd0);

        // Disabled: edges dropped silently
        inc    = 6'd4;
        enable = 1'b0;
        set_dir(1'b1);
        moved_seen = 0;
        for (int k = 0; k < 5; k++) begin
            step_pulse(lat);
            if (lat != 0) moved_seen++;
        end
        check("dis_moved", 32'(moved_seen), 32'd0);
        check("dis_pos", 32'(pos), 32'd8);
        check("dis_count", count, 32'd0);
        check("dis_err", 32'(inc_err), 32'd0);
        enable = 1'b1;

        // Load in the same cycle the edge is detected
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load     = 1'b1;
        load_pos = 8'd50;
        @(negedge clk);
        load = 1'b0;
        check("coll_pos", 32'(pos), 32'd50);
        check("coll_moved", 32'(moved), 32'd0);
        moved_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (moved) moved_seen++;
            if (k == 1) step = 1'b0;
        end
        check("coll_no_move", 32'(moved_seen), 32'd0);
        check("coll_pos_after", 32'(pos), 32'd50);

        step_pulse(lat);
        check("post_coll_pos", 32'(pos), 32'd54);

        // Reset between edge 2 and edge 3 of a step
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_count", count, 32'd0);
        check("rst_moved", 32'(moved), 32'd0);
        check("rst_err", 32'(inc_err), 32'd0);
        step = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        moved_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (moved) moved_seen++;
        end
        check("rst_no_move", 32'(moved_seen), 32'd0);
        check("rst_pos_after", 32'(pos), 32'd0);
        check("rst_count_after", count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
